// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM command arbiter.
package sdram_arb_pkg;

    localparam int DEFAULT_MAX_OUTSTANDING = 4;
    localparam int TAG_PTR_W               = $clog2(DEFAULT_MAX_OUTSTANDING);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_R0 = 1'b0,
        OWNER_R1 = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// 1-bit-wide owner-tag FIFO; remembers which requester each in-flight read belongs to.
module arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_data,
    input  logic             pop,
    output logic             pop_data,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != FULL_COUNT);
    assign do_pop   = pop && (count != '0);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdram_request_arbiter.sv
// Arbitrates r0 (playback, priority) and r1 (loader) onto one SDRAM controller port.
// Define SDRAM_ARB_STARVE_GUARD_EN to force an r1 win after STARVE_LIMIT lost cycles.
module sdram_request_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int STARVE_LIMIT    = 16
) (
    input  logic              max10Board_50MhzClock,
    input  logic              reset_n,
    input  logic              r0_reqValid,
    input  logic              r0_reqWrite,
    input  logic [ADDR_W-1:0] r0_reqAddress,
    input  logic [DATA_W-1:0] r0_reqWriteData,
    output logic              r0_reqReady,
    output logic              r0_rspValid,
    output logic [DATA_W-1:0] r0_rspData,
    input  logic              r1_reqValid,
    input  logic              r1_reqWrite,
    input  logic [ADDR_W-1:0] r1_reqAddress,
    input  logic [DATA_W-1:0] r1_reqWriteData,
    output logic              r1_reqReady,
    output logic              r1_rspValid,
    output logic [DATA_W-1:0] r1_rspData,
    output logic [ADDR_W-1:0] ctl_address,
    output logic              ctl_read,
    output logic              ctl_write,
    output logic [DATA_W-1:0] ctl_writeData,
    input  logic              ctl_waitRequest,
    input  logic [DATA_W-1:0] ctl_readData,
    input  logic              ctl_readDataValid,
    output logic              err_orphanResponse,
    output arb_state_t        dbg_state
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // Handshake: a request transfers on a rising edge where rN_reqValid and
    // rN_reqReady are both 1; the requester holds its fields stable until then.

    arb_state_t        state;
    arb_state_t        state_next;
    arb_owner_t        owner;
    logic              accept;
    logic              can_latch;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  outstanding;
    logic              read_ok;
    logic              r0_elig;
    logic              r1_elig;
    logic              force_r1;
    logic              grant_r0;
    logic              grant_r1;
    logic              fifo_empty;
    logic              fifo_head;

    assign accept      = (state == ST_ISSUE) && !ctl_waitRequest;
    assign can_latch   = reset_n && ((state == ST_IDLE) || accept);
    // A read sitting in ST_ISSUE is counted so the FIFO can never overflow.
    assign outstanding = fifo_count + CNT_W'((state == ST_ISSUE) && ctl_read);
    assign read_ok     = (outstanding < MAX_CNT);
    assign r0_elig     = r0_reqValid && (r0_reqWrite || read_ok);
    assign r1_elig     = r1_reqValid && (r1_reqWrite || read_ok);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    always_ff @(posedge max10Board_50MhzClock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_r1) begin
            starve_cnt <= '0;
        end else if (r1_elig && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_r1 = (starve_cnt == STARVE_MAX);
`else
    assign force_r1 = 1'b0;
`endif

    // State register
    always_ff @(posedge max10Board_50MhzClock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (grant_r0 || grant_r1) state_next = ST_ISSUE;
            ST_ISSUE: if (accept && !(grant_r0 || grant_r1)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic: grant decision and handshake
    always_comb begin
        grant_r0    = can_latch && r0_elig && !(force_r1 && r1_elig);
        grant_r1    = can_latch && r1_elig && !grant_r0;
        r0_reqReady = grant_r0;
        r1_reqReady = grant_r1;
    end

    assign dbg_state = state;

    always_ff @(posedge max10Board_50MhzClock or negedge reset_n) begin
        if (!reset_n) begin
            ctl_address   <= '0;
            ctl_writeData <= '0;
            ctl_read      <= 1'b0;
            ctl_write     <= 1'b0;
            owner         <= OWNER_R0;
        end else if (grant_r0) begin
            ctl_address   <= r0_reqAddress;
            ctl_writeData <= r0_reqWriteData;
            ctl_read      <= !r0_reqWrite;
            ctl_write     <= r0_reqWrite;
            owner         <= OWNER_R0;
        end else if (grant_r1) begin
            ctl_address   <= r1_reqAddress;
            ctl_writeData <= r1_reqWriteData;
            ctl_read      <= !r1_reqWrite;
            ctl_write     <= r1_reqWrite;
            owner         <= OWNER_R1;
        end else if (accept) begin
            ctl_read      <= 1'b0;
            ctl_write     <= 1'b0;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .PTR_W (PTR_W)
    ) u_tag_fifo (
        .clk       (max10Board_50MhzClock),
        .rst_n     (reset_n),
        .push      (accept && ctl_read),
        .push_data (owner == OWNER_R1),
        .pop       (ctl_readDataValid),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read data is routed by the tag at the FIFO head; an empty FIFO means an orphan.
    always_ff @(posedge max10Board_50MhzClock or negedge reset_n) begin
        if (!reset_n) begin
            r0_rspValid        <= 1'b0;
            r1_rspValid        <= 1'b0;
            r0_rspData         <= '0;
            r1_rspData         <= '0;
            err_orphanResponse <= 1'b0;
        end else begin
            r0_rspValid <= ctl_readDataValid && !fifo_empty && !fifo_head;
            r1_rspValid <= ctl_readDataValid && !fifo_empty && fifo_head;
            if (ctl_readDataValid && !fifo_empty && !fifo_head) r0_rspData <= ctl_readData;
            if (ctl_readDataValid && !fifo_empty && fifo_head)  r1_rspData <= ctl_readData;
            if (ctl_readDataValid && fifo_empty) err_orphanResponse <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Directed bench for sdram_request_arbiter with command and response scoreboards.
module tb_sdram_request_arbiter;
  import sdram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_reqValid, r0_reqWrite, r0_reqReady, r0_rspValid;
  logic [24:0] r0_reqAddress;
  logic [15:0] r0_reqWriteData, r0_rspData;
  logic        r1_reqValid, r1_reqWrite, r1_reqReady, r1_rspValid;
  logic [24:0] r1_reqAddress;
  logic [15:0] r1_reqWriteData, r1_rspData;
  logic [24:0] ctl_address;
  logic        ctl_read, ctl_write, ctl_waitRequest, ctl_readDataValid;
  logic [15:0] ctl_writeData, ctl_readData;
  logic        err_orphanResponse;
  arb_state_t  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [41:0] cmd_q[$];
  logic [17:0] rsp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  sdram_request_arbiter dut (
    .max10Board_50MhzClock (clk),
    .reset_n               (reset_n),
    .r0_reqValid           (r0_reqValid),
    .r0_reqWrite           (r0_reqWrite),
    .r0_reqAddress         (r0_reqAddress),
    .r0_reqWriteData       (r0_reqWriteData),
    .r0_reqReady           (r0_reqReady),
    .r0_rspValid           (r0_rspValid),
    .r0_rspData            (r0_rspData),
    .r1_reqValid           (r1_reqValid),
    .r1_reqWrite           (r1_reqWrite),
    .r1_reqAddress         (r1_reqAddress),
    .r1_reqWriteData       (r1_reqWriteData),
    .r1_reqReady           (r1_reqReady),
    .r1_rspValid           (r1_rspValid),
    .r1_rspData            (r1_rspData),
    .ctl_address           (ctl_address),
    .ctl_read              (ctl_read),
    .ctl_write             (ctl_write),
    .ctl_writeData         (ctl_writeData),
    .ctl_waitRequest       (ctl_waitRequest),
    .ctl_readData          (ctl_readData),
    .ctl_readDataValid     (ctl_readDataValid),
    .err_orphanResponse    (err_orphanResponse),
    .dbg_state             (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] cmd_word(input logic wr, input logic [24:0] a, input logic [15:0] d);
    return {wr, a, wr ? d : 16'h0000};
  endfunction

  // scoreboard: controller command acceptance
  always @(negedge clk) begin
    logic [41:0] obs;
    if (reset_n && (ctl_read || ctl_write)) begin
      check("ctl_excl", 64'(ctl_read & ctl_write), 64'd0);
      if (!ctl_waitRequest) begin
        obs = cmd_word(ctl_write, ctl_address, ctl_writeData);
        if (cmd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL cmd_unexpected: observed %0h expected none", obs);
        end else begin
          check("cmd", 64'(obs), 64'(cmd_q.pop_front()));
        end
      end
    end
  end

  // scoreboard: read responses
  always @(negedge clk) begin
    logic [17:0] obs;
    if (r0_rspValid || r1_rspValid) begin
      obs = {r1_rspValid, r0_rspValid, r1_rspValid ? r1_rspData : r0_rspData};
      if (rsp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL rsp_unexpected: observed %0h expected none", obs);
      end else begin
        check("rsp", 64'(obs), 64'(rsp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic wr, input logic [24:0] a, input logic [15:0] d);
    if (port == 0) begin
      r0_reqValid = v; r0_reqWrite = wr; r0_reqAddress = a; r0_reqWriteData = d;
    end else begin
      r1_reqValid = v; r1_reqWrite = wr; r1_reqAddress = a; r1_reqWriteData = d;
    end
  endtask

  task automatic wait_grant(input int port, input string tag);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ((port == 0) ? r0_reqReady : r1_reqReady) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 64'(got), 64'd1);
    tick();
    if (port == 0) r0_reqValid = 1'b0;
    else           r1_reqValid = 1'b0;
  endtask

  task automatic do_req(input int port, input logic wr, input logic [24:0] a, input logic [15:0] d, input string tag);
    cmd_q.push_back(cmd_word(wr, a, d));
    set_req(port, 1'b1, wr, a, d);
    wait_grant(port, tag);
  endtask

  task automatic respond(input int owner, input logic [15:0] d, input logic orphan);
    if (!orphan) rsp_q.push_back({owner == 1, owner == 0, d});
    ctl_readDataValid = 1'b1;
    ctl_readData      = d;
    tick();
    ctl_readDataValid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({ctl_read, ctl_write, ctl_address, ctl_writeData}), 64'd0);
    check({tag, "_ready"}, 64'({r0_reqReady, r1_reqReady}), 64'd0);
    check({tag, "_rsp"}, 64'({r0_rspValid, r1_rspValid, r0_rspData, r1_rspData}), 64'd0);
    check({tag, "_err"}, 64'(err_orphanResponse), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    logic [24:0] a0;
    logic [15:0] d0;
    logic        exp_r1;
    logic        r1_pend;

    reset_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    ctl_waitRequest = 1'b0;
    ctl_readData = '0;
    ctl_readDataValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single r0 read
    cmd_q.push_back(cmd_word(1'b0, 25'h10, 16'h0));
    set_req(0, 1'b1, 1'b0, 25'h10, 16'h0);
    @(negedge clk);
    check("t1_r0_ready", 64'(r0_reqReady), 64'd1);
    check("t1_r1_ready", 64'(r1_reqReady), 64'd0);
    tick();
    r0_reqValid = 1'b0;
    @(negedge clk);
    check("t1_ctl_read", 64'({ctl_read, ctl_write, ctl_address}), 64'({2'b10, 25'h10}));
    check("t1_no_ready", 64'(r0_reqReady), 64'd0);
    tick();
    @(negedge clk);
    check("t1_read_drop", 64'(ctl_read), 64'd0);
    tick();
    tick();
    respond(0, 16'hA5A5, 1'b0);
    @(negedge clk);
    check("t1_rsp", 64'({r1_rspValid, r0_rspValid, r0_rspData}), 64'({2'b01, 16'hA5A5}));
    tick();

    // 2: simultaneous requests, r0 first
    cmd_q.push_back(cmd_word(1'b0, 25'h20, 16'h0));
    cmd_q.push_back(cmd_word(1'b1, 25'h1FFFFFF, 16'h1234));
    set_req(0, 1'b1, 1'b0, 25'h20, 16'h0);
    set_req(1, 1'b1, 1'b1, 25'h1FFFFFF, 16'h1234);
    @(negedge clk);
    check("t2_first", 64'({r0_reqReady, r1_reqReady}), 64'b10);
    tick();
    r0_reqValid = 1'b0;
    @(negedge clk);
    check("t2_second", 64'({r0_reqReady, r1_reqReady}), 64'b01);
    check("t2_ctl_r0", 64'({ctl_read, ctl_address}), 64'({1'b1, 25'h20}));
    tick();
    r1_reqValid = 1'b0;
    @(negedge clk);
    check("t2_ctl_r1", 64'({ctl_write, ctl_address, ctl_writeData}), 64'({1'b1, 25'h1FFFFFF, 16'h1234}));
    tick();
    respond(0, 16'hBEEF, 1'b0);
    tick();

    // 3: waitRequest stall on r1 write
    ctl_waitRequest = 1'b1;
    cmd_q.push_back(cmd_word(1'b1, 25'h0ABCDE, 16'h55AA));
    set_req(1, 1'b1, 1'b1, 25'h0ABCDE, 16'h55AA);
    @(negedge clk);
    check("t3_ready", 64'(r1_reqReady), 64'd1);
    tick();
    r1_reqValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold", 64'({ctl_write, ctl_address, ctl_writeData, r1_reqReady}),
            64'({1'b1, 25'h0ABCDE, 16'h55AA, 1'b0}));
      tick();
    end
    ctl_waitRequest = 1'b0;
    tick();
    @(negedge clk);
    check("t3_release", 64'({ctl_write, dbg_state}), 64'({1'b0, ST_IDLE}));
    tick();

    // 4: outstanding-read limit
    for (int i = 0; i < 4; i++) do_req(0, 1'b0, 25'(32'h100 + i), 16'h0, "t4_read");
    set_req(0, 1'b1, 1'b0, 25'h104, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_blocked", 64'(r0_reqReady), 64'd0);
      tick();
    end
    do_req(1, 1'b1, 25'h777, 16'h7777, "t4_write");
    cmd_q.push_back(cmd_word(1'b0, 25'h104, 16'h0));
    respond(0, 16'h1000, 1'b0);
    wait_grant(0, "t4_fifth");
    respond(0, 16'h1001, 1'b0);
    do_req(1, 1'b0, 25'h200, 16'h0, "t4_r1_read");
    respond(0, 16'h1002, 1'b0);
    respond(0, 16'h1003, 1'b0);
    respond(0, 16'h1004, 1'b0);
    respond(1, 16'h2000, 1'b0);
    tick();

    // 6: r0 continuous writes against a pending r1 read
    r1_pend = 1'b1;
    set_req(1, 1'b1, 1'b0, 25'h300, 16'h0);
    a0 = 25'h400;
    d0 = 16'($urandom_range(0, 16'hFFFF));
    set_req(0, 1'b1, 1'b1, a0, d0);
    for (int i = 0; i < 200; i++) begin
      exp_r1 = 1'b0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      exp_r1 = (i == 16);
`endif
      @(negedge clk);
      check("t6_r0_ready", 64'(r0_reqReady), 64'(!exp_r1));
      check("t6_r1_ready", 64'(r1_reqReady), 64'(exp_r1));
      if (exp_r1) cmd_q.push_back(cmd_word(1'b0, 25'h300, 16'h0));
      else        cmd_q.push_back(cmd_word(1'b1, a0, d0));
      tick();
      if (exp_r1) begin
        r1_reqValid = 1'b0;
        r1_pend = 1'b0;
      end else begin
        a0 = a0 + 1'b1;
        d0 = 16'($urandom_range(0, 16'hFFFF));
        set_req(0, 1'b1, 1'b1, a0, d0);
      end
    end
    r0_reqValid = 1'b0;
    if (r1_pend) begin
      cmd_q.push_back(cmd_word(1'b0, 25'h300, 16'h0));
      wait_grant(1, "t6_r1_late");
    end
    tick();
    respond(1, 16'h3333, 1'b0);
    tick();

    // 5: orphan response, then reset mid-issue
    respond(0, 16'hDEAD, 1'b1);
    @(negedge clk);
    check("t5_orphan", 64'(err_orphanResponse), 64'd1);
    tick();
    tick();
    @(negedge clk);
    check("t5_sticky", 64'(err_orphanResponse), 64'd1);
    tick();
    ctl_waitRequest = 1'b1;
    set_req(1, 1'b1, 1'b1, 25'h55, 16'h9999);
    @(negedge clk);
    check("t5_grant", 64'(r1_reqReady), 64'd1);
    tick();
    r1_reqValid = 1'b0;
    @(negedge clk);
    check("t5_issue", 64'({ctl_write, dbg_state}), 64'({1'b1, ST_ISSUE}));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    tick();
    reset_n = 1'b1;
    ctl_waitRequest = 1'b0;
    tick();
    respond(0, 16'hCAFE, 1'b1);
    @(negedge clk);
    check("t5_late_orphan", 64'({err_orphanResponse, r0_rspValid, r1_rspValid}), 64'b100);
    tick();
    tick();

    check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
